// File: rtl/apb_lsu_arb.sv
// Round-robin arbiter that turns NCH load/store request channels into APB master transfers.
// Handles byte lanes, write strobes, read extension, misalignment and the pready timeout.
module apb_lsu_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NCH        = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rts_n,
    input  logic [NCH-1:0]            req_valid,
    output logic [NCH-1:0]            req_ready,
    input  logic [NCH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NCH*DATA_WIDTH-1:0] req_wdata,
    input  logic [NCH-1:0]            req_write,
    input  logic [NCH*2-1:0]          req_size,
    input  logic [NCH-1:0]            req_unsigned,
    output logic [NCH-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_WIDTH-1:0]     APB_paddr,
    output logic [DATA_WIDTH-1:0]     APB_pdata,
    input  logic [DATA_WIDTH-1:0]     APB_prdata,
    output logic                      APB_psel,
    output logic                      APB_penable,
    output logic                      APB_pwrite,
    output logic [DATA_WIDTH/8-1:0]   APB_pstb,
    input  logic                      APB_pready,
    input  logic                      APB_perr
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LG    = $clog2(BYTES);
    localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [PW-1:0]           ptr_reg, ptr_next;
    logic [PW-1:0]           gnt_reg, gnt_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic                    write_reg, write_next;
    logic [1:0]              size_reg, size_next;
    logic                    uns_reg, uns_next;
    logic                    err_reg, err_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic [TW-1:0]           tcnt_reg, tcnt_next;

    logic [ADDR_WIDTH-1:0]   ch_addr  [NCH];
    logic [DATA_WIDTH-1:0]   ch_wdata [NCH];
    logic [1:0]              ch_size  [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign ch_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign ch_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign ch_size[gi]  = req_size[gi*2 +: 2];
            assign rsp_valid[gi] = (state_reg == RESP) && (gnt_reg == PW'(gi));
        end
    endgenerate

    // First valid channel at or after the pointer, wrapping around.
    logic          found;
    logic [PW-1:0] gnt;
    always_comb begin
        int idx;
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = PW'(idx);
            end
        end
    end

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [1:0]            sel_size;
    logic                  sel_illegal;
    assign sel_addr = ch_addr[gnt];
    assign sel_size = ch_size[gnt];

    always_comb begin
        logic misal;
        misal = 1'b0;
        for (int b = 0; b < LG; b++) begin
            if ((b < int'(sel_size)) && sel_addr[b]) misal = 1'b1;
        end
        sel_illegal = (int'(sel_size) > LG) || misal;
    end

    logic [LG-1:0] off;
    assign off = addr_reg[LG-1:0];

    // Read data: drop the lanes below the address, keep 2^size bytes, extend the rest.
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ext_rdata;
    always_comb begin
        int nb;
        shifted = APB_prdata >> {off, 3'b000};
        nb = 8 << size_reg;
        if (nb > DATA_WIDTH) nb = DATA_WIDTH;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < nb) ext_rdata[i] = shifted[i];
            else        ext_rdata[i] = !uns_reg && shifted[nb-1];
        end
    end

    logic [BYTES-1:0] wr_stb;
    always_comb begin
        for (int b = 0; b < BYTES; b++) begin
            wr_stb[b] = (b >= int'(off)) && (b < int'(off) + (1 << size_reg));
        end
    end

    always_ff @(posedge clk or negedge rts_n) begin
        if (!rts_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            write_reg <= 1'b0;
            size_reg  <= 2'd0;
            uns_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
            tcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            write_reg <= write_next;
            size_reg  <= size_next;
            uns_reg   <= uns_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
            tcnt_reg  <= tcnt_next;
        end
    end

    logic [NCH-1:0] ready_int;
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        write_next = write_reg;
        size_next  = size_reg;
        uns_next   = uns_reg;
        err_next   = err_reg;
        rdata_next = rdata_reg;
        tcnt_next  = tcnt_reg;
        ready_int  = '0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    ready_int[gnt] = 1'b1;
                    gnt_next   = gnt;
                    ptr_next   = (gnt == PW'(NCH - 1)) ? '0 : gnt + PW'(1);
                    addr_next  = sel_addr;
                    wdata_next = ch_wdata[gnt];
                    write_next = req_write[gnt];
                    size_next  = sel_size;
                    uns_next   = req_unsigned[gnt];
                    err_next   = sel_illegal;
                    rdata_next = '0;
                    state_next = sel_illegal ? RESP : SETUP;
                end
            end
            SETUP: begin
                tcnt_next  = '0;
                state_next = ACCESS;
            end
            ACCESS: begin
                if (APB_pready) begin
                    err_next   = APB_perr;
                    rdata_next = (APB_perr || write_reg) ? '0 : ext_rdata;
                    state_next = RESP;
                end else if (TIMEOUT != 0) begin
                    if (tcnt_reg == TW'(TIMEOUT - 1)) begin
                        err_next   = 1'b1;
                        rdata_next = '0;
                        state_next = RESP;
                    end else begin
                        tcnt_next = tcnt_reg + TW'(1);
                    end
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The grant path is combinational on req_valid, so hold it low while reset is active.
    assign req_ready = ready_int & {NCH{rts_n}};

    assign APB_psel    = (state_reg == SETUP) || (state_reg == ACCESS);
    assign APB_penable = (state_reg == ACCESS);
    assign APB_paddr   = APB_psel ? addr_reg : '0;
    assign APB_pwrite  = APB_psel && write_reg;
    assign APB_pdata   = (APB_psel && write_reg) ? (wdata_reg << {off, 3'b000}) : '0;
    assign APB_pstb    = APB_psel ? (write_reg ? wr_stb : {BYTES{1'b1}}) : '0;

    assign rsp_rdata = (state_reg == RESP) ? rdata_reg : '0;
    assign rsp_err   = (state_reg == RESP) && err_reg;

endmodule
